// File: rtl/b200_spi_arbiter_if.sv
// Requester-side bus of the shared SPI arbiter: per-requester command fields,
// accept/complete pulses, shared readback word and busy flag.
interface b200_spi_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int SEN_WIDTH = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*SEN_WIDTH-1:0] req_sen;
  logic [NUM_REQ*6-1:0]         req_len;
  logic [NUM_REQ*32-1:0]        req_data;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [31:0]                  rsp_data;
  logic                         busy;

  modport master (
    output req_valid, req_sen, req_len, req_data,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_sen, req_len, req_data,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/b200_spi_arbiter.sv
// Round-robin arbiter that owns the board SPI pins and runs one transfer of
// up to 32 bits for the granted requester, returning MISO readback.
//
// state    | meaning
// IDLE     | waiting for a request; grant and capture happen here
// SETUP    | sen asserted, first MOSI bit presented, sclk low
// SHIFT_HI | sclk high, MISO sampled on the first cycle
// SHIFT_LO | sclk low, MOSI advanced to the next bit
// HOLD     | sclk low after the last bit, sen still asserted
// DONE     | sen released, completion pulse to the owner
module b200_spi_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int SEN_WIDTH = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                 bus_clk,
  input  logic                 bus_rst,
  b200_spi_arbiter_if.slave    req_bus,
  output logic [SEN_WIDTH-1:0] sen,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [PW:0]   NUM_REQ_W = (PW+1)'(NUM_REQ);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [2:0]           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        owner;
  logic [CW-1:0]        cnt;
  logic [4:0]           bits_left;
  logic [31:0]          tx;
  logic [31:0]          rx;
  logic [SEN_WIDTH-1:0] mask;

  logic                 grant;
  logic [PW-1:0]        win;
  logic [PW:0]          cand;
  logic [PW:0]          nxt;
  logic [PW-1:0]        ptr_next;
  logic [SEN_WIDTH-1:0] sel_sen;
  logic [5:0]           sel_len;
  logic [31:0]          sel_data;
  logic [5:0]           len_eff;
  logic                 active;

  // Pick the first valid requester at or after the pointer; only grant from IDLE.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PW+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant && req_bus.req_valid[cand[PW-1:0]]) begin
        grant = 1'b1;
        win   = cand[PW-1:0];
      end
    end
    if (bus_rst || state != ST_IDLE) grant = 1'b0;
  end

  // Winner's fields, clamped length and the rotated pointer.
  always_comb begin
    sel_sen  = req_bus.req_sen[win*SEN_WIDTH +: SEN_WIDTH];
    sel_len  = req_bus.req_len[win*6 +: 6];
    sel_data = req_bus.req_data[win*32 +: 32];
    len_eff  = (sel_len > 6'd32) ? 6'd32 : sel_len;
    nxt      = {1'b0, win} + (PW+1)'(1);
    if (nxt >= NUM_REQ_W) nxt = '0;
    ptr_next = nxt[PW-1:0];
  end

  // Transfer sequencer: phase timer counts down from CLK_DIV-1 in every timed state.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      bits_left <= '0;
      tx        <= '0;
      rx        <= '0;
      mask      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner     <= win;
            ptr       <= ptr_next;
            mask      <= sel_sen;
            tx        <= sel_data;
            rx        <= '0;
            cnt       <= DIV_LAST;
            bits_left <= 5'(len_eff - 6'd1);
            state     <= (sel_len == 6'd0) ? ST_DONE : ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            cnt   <= DIV_LAST;
            state <= ST_SHIFT_HI;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SHIFT_HI: begin
          if (cnt == DIV_LAST) rx <= {rx[30:0], miso};
          if (cnt == '0) begin
            cnt <= DIV_LAST;
            if (bits_left == 5'd0) begin
              state <= ST_HOLD;
            end else begin
              bits_left <= bits_left - 5'd1;
              tx        <= {tx[30:0], 1'b0};
              state     <= ST_SHIFT_LO;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_SHIFT_LO: begin
          if (cnt == '0) begin
            cnt   <= DIV_LAST;
            state <= ST_SHIFT_HI;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == '0) state <= ST_DONE;
          else cnt <= cnt - CW'(1);
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pin and handshake outputs decoded from state.
  always_comb begin
    active = (state == ST_SETUP) || (state == ST_SHIFT_HI) ||
             (state == ST_SHIFT_LO) || (state == ST_HOLD);
    sen    = active ? ~mask : '1;
    sclk   = (state == ST_SHIFT_HI);
    mosi   = active && tx[31];
    req_bus.req_ready = '0;
    req_bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bus.req_ready[i] = grant && (win == PW'(i));
      req_bus.rsp_valid[i] = (state == ST_DONE) && (owner == PW'(i));
    end
    req_bus.rsp_data = rx;
    req_bus.busy     = (state != ST_IDLE) || grant;
  end

endmodule
